// File: rtl/garnet_reset_seq_if.sv
// rtl/garnet_reset_seq_if.sv - control/status bundle between a reset-sequence requester and garnet_reset_seq
interface garnet_reset_seq_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 8,
  parameter int TO_WIDTH  = 16
);
  logic                 start;
  logic [CNT_WIDTH-1:0] pre_cycles;
  logic [CNT_WIDTH-1:0] assert_cycles;
  logic [CNT_WIDTH-1:0] stagger;
  logic                 interrupt;
  logic [TO_WIDTH-1:0]  to_cycles;
  logic [NUM_CH-1:0]    rst_out;
  logic                 busy;
  logic                 done;
  logic                 timeout;

  modport master (
    output start, pre_cycles, assert_cycles, stagger, interrupt, to_cycles,
    input  rst_out, busy, done, timeout
  );

  modport slave (
    input  start, pre_cycles, assert_cycles, stagger, interrupt, to_cycles,
    output rst_out, busy, done, timeout
  );
endinterface

// File: rtl/garnet_reset_seq.sv
// rtl/garnet_reset_seq.sv - staggered multi-channel reset-pulse sequencer
// Optional interrupt watchdog compiled in with GARNET_RESET_SEQ_WATCHDOG_EN.
module garnet_reset_seq #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 8,
  parameter int TO_WIDTH  = 16
) (
  input logic               clk,
  input logic               reset_n,
  garnet_reset_seq_if.slave bus
);
  // Wide enough for (NUM_CH-1)*stagger, so the release counter never wraps.
  localparam int RW = CNT_WIDTH + $clog2(NUM_CH);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ASSERT,
    RELEASE,
    WAIT_IRQ,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [RW-1:0]        rel_cnt, rel_nxt;
  logic [CNT_WIDTH-1:0] pre_l, pre_nxt;
  logic [CNT_WIDTH-1:0] assert_l, assert_nxt;
  logic [CNT_WIDTH-1:0] stagger_l, stagger_nxt;
  logic [NUM_CH-1:0]    rst_q, rst_nxt;
  logic                 busy_q, busy_nxt;
  logic                 done_q, done_nxt;
  logic [CNT_WIDTH-1:0] assert_last;
  logic [RW-1:0]        rel_last;

`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
  logic [TO_WIDTH-1:0]  to_l, to_nxt;
  logic [TO_WIDTH:0]    wd_cnt, wd_nxt, wd_inc;
  logic                 timeout_q, timeout_nxt;
`else
  logic                 unused_wd;
  assign unused_wd = ^{bus.interrupt, bus.to_cycles};
`endif

  // A zero assert length still produces a single-cycle pulse.
  assign assert_last = (assert_l == '0) ? '0 : assert_l - 1'b1;
  assign rel_last    = RW'(NUM_CH - 1) * RW'(stagger_l);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rel_nxt     = rel_cnt;
    pre_nxt     = pre_l;
    assert_nxt  = assert_l;
    stagger_nxt = stagger_l;
`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
    to_nxt      = to_l;
    wd_nxt      = wd_cnt;
    wd_inc      = wd_cnt + 1'b1;
    timeout_nxt = timeout_q;
`endif

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          pre_nxt     = bus.pre_cycles;
          assert_nxt  = bus.assert_cycles;
          stagger_nxt = bus.stagger;
          cnt_nxt     = '0;
          rel_nxt     = '0;
`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
          to_nxt      = bus.to_cycles;
          wd_nxt      = '0;
          timeout_nxt = 1'b0;
`endif
          state_nxt   = (bus.pre_cycles == '0) ? ASSERT : PRE;
        end
      end
      PRE: begin
        if (cnt == pre_l - 1'b1) begin
          cnt_nxt   = '0;
          state_nxt = ASSERT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ASSERT: begin
        if (cnt == assert_last) begin
          cnt_nxt   = '0;
          rel_nxt   = '0;
          state_nxt = RELEASE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (rel_cnt == rel_last) begin
`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
          wd_nxt    = '0;
          state_nxt = WAIT_IRQ;
`else
          state_nxt = DONE;
`endif
        end else begin
          rel_nxt = rel_cnt + 1'b1;
        end
      end
`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
      WAIT_IRQ: begin
        // Interrupt has priority over an expiry in the same cycle.
        if (bus.interrupt) begin
          state_nxt = DONE;
        end else if (wd_inc >= {1'b0, to_l}) begin
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          wd_nxt = wd_inc;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    rst_nxt = '0;
    if (state_nxt == ASSERT) begin
      rst_nxt = '1;
    end else if (state_nxt == RELEASE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rst_nxt[i] = (rel_nxt < RW'(i) * RW'(stagger_l));
      end
    end
    busy_nxt = (state_nxt == PRE) || (state_nxt == ASSERT) ||
               (state_nxt == RELEASE) || (state_nxt == WAIT_IRQ);
    done_nxt = (state_nxt == DONE) && (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rel_cnt   <= '0;
      pre_l     <= '0;
      assert_l  <= '0;
      stagger_l <= '0;
      rst_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
      to_l      <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rel_cnt   <= rel_nxt;
      pre_l     <= pre_nxt;
      assert_l  <= assert_nxt;
      stagger_l <= stagger_nxt;
      rst_q     <= rst_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
      to_l      <= to_nxt;
      wd_cnt    <= wd_nxt;
      timeout_q <= timeout_nxt;
`endif
    end
  end

  assign bus.rst_out = rst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_garnet_reset_seq.sv
// tb/tb_garnet_reset_seq.sv - randomized bench for garnet_reset_seq against a cycle-offset reference model
`timescale 1ns/1ps
module tb_garnet_reset_seq;
  localparam int NUM_CH    = 4;
  localparam int CNT_WIDTH = 8;
  localparam int TO_WIDTH  = 16;

  typedef struct {
    int p;
    int a;
    int s;
    int to;
    int j;
    bit chain;
  } seq_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   last_timeout = 1'b0;
  seq_t seqs[$];

  garnet_reset_seq_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .TO_WIDTH(TO_WIDTH)) bus ();

  garnet_reset_seq #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .TO_WIDTH(TO_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel i is high from the first cycle after the pre phase through
  // assert length plus i*stagger cycles; t counts cycles after the start edge.
  function automatic logic [NUM_CH-1:0] exp_rst(input int t, input int p, input int aa, input int s);
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = (t > p) && (t <= p + aa + i * s);
    return r;
  endfunction

  task automatic launch(input seq_t c);
    bus.pre_cycles    = CNT_WIDTH'(c.p);
    bus.assert_cycles = CNT_WIDTH'(c.a);
    bus.stagger       = CNT_WIDTH'(c.s);
    bus.to_cycles     = TO_WIDTH'(c.to);
    bus.start         = 1'b1;
  endtask

  task automatic check_idle(input string tag, input bit exp_to);
    check_eq({tag, " rst_out"}, 32'(bus.rst_out), 32'd0);
    check_eq({tag, " busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, " done"}, 32'(bus.done), 32'd0);
    check_eq({tag, " timeout"}, 32'(bus.timeout), 32'(exp_to));
  endtask

  task automatic idle_then_launch(input seq_t c, input int g);
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle%0d", i), last_timeout);
      if (i == g - 1) launch(c);
      else bus.start = 1'b0;
      bus.interrupt = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_one(input int k, input seq_t c, input bit chain_next, input seq_t n, input int abort_t);
    int aa = (c.a == 0) ? 1 : c.a;
    int rl = (NUM_CH - 1) * c.s + 1;
    int w0 = c.p + aa + rl + 1;
    int lim = (c.to == 0) ? 1 : c.to;
    int d;
    bit to_hit;
`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
    if (c.j < lim) begin
      d = w0 + c.j + 1;
      to_hit = 1'b0;
    end else begin
      d = w0 + lim;
      to_hit = 1'b1;
    end
`else
    d = w0;
    to_hit = 1'b0;
    lim = 0;
`endif
    for (int t = 1; t <= d; t++) begin
      @(negedge clk);
      check_eq($sformatf("s%0d t%0d rst_out", k, t), 32'(bus.rst_out), 32'(exp_rst(t, c.p, aa, c.s)));
      check_eq($sformatf("s%0d t%0d busy", k, t), 32'(bus.busy), 32'(t < d));
      check_eq($sformatf("s%0d t%0d done", k, t), 32'(bus.done), 32'(t == d));
      check_eq($sformatf("s%0d t%0d timeout", k, t), 32'(bus.timeout), 32'((t == d) && to_hit));
      if (t == abort_t) begin
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.interrupt = 1'b0;
        @(negedge clk);
        check_idle($sformatf("s%0d abort", k), 1'b0);
        reset_n = 1'b1;
        last_timeout = 1'b0;
        return;
      end
      if (t < d) begin
        bus.start         = ($urandom_range(0, 3) == 0);
        bus.pre_cycles    = CNT_WIDTH'($urandom_range(0, 255));
        bus.assert_cycles = CNT_WIDTH'($urandom_range(0, 255));
        bus.stagger       = CNT_WIDTH'($urandom_range(0, 255));
        bus.to_cycles     = TO_WIDTH'($urandom_range(0, 255));
      end else if (chain_next) begin
        launch(n);
      end else begin
        bus.start = 1'b0;
      end
`ifdef GARNET_RESET_SEQ_WATCHDOG_EN
      bus.interrupt = (t == w0 + c.j);
`else
      bus.interrupt = 1'($urandom_range(0, 1));
`endif
    end
    last_timeout = to_hit;
  endtask

  function automatic seq_t mk(input int p, input int a, input int s, input int to, input int j, input bit chain);
    seq_t r;
    r.p = p; r.a = a; r.s = s; r.to = to; r.j = j; r.chain = chain;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    seq_t nx;
    bit   ch;
    bus.start = 1'b0;
    bus.interrupt = 1'b0;
    bus.pre_cycles = '0;
    bus.assert_cycles = '0;
    bus.stagger = '0;
    bus.to_cycles = '0;
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("reset", 1'b0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle($sformatf("post_reset%0d", i), 1'b0);
    end

    seqs.push_back(mk(3, 3, 0, 10, 100, 1'b0));
    seqs.push_back(mk(0, 2, 2, 10, 100, 1'b0));
    seqs.push_back(mk(2, 0, 1, 10, 0, 1'b1));
    seqs.push_back(mk(1, 2, 1, 10, 5, 1'b0));
    seqs.push_back(mk(0, 1, 0, 10, 100, 1'b0));
    seqs.push_back(mk(1, 1, 0, 0, 0, 1'b1));
    seqs.push_back(mk(0, 0, 0, 0, 100, 1'b0));
    for (int i = 0; i < 12; i++) begin
      seqs.push_back(mk($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                        $urandom_range(0, 8), $urandom_range(0, 10), 1'($urandom_range(0, 1))));
    end
    seqs.push_back(mk(2, 5, 1, 10, 100, 1'b0));
    seqs.push_back(mk(3, 3, 0, 4, 2, 1'b0));

    for (int k = 0; k < seqs.size(); k++) begin
      ch = (k + 1 < seqs.size()) && seqs[k + 1].chain && (k != seqs.size() - 3);
      nx = (k + 1 < seqs.size()) ? seqs[k + 1] : seqs[k];
      if (k == 0 || !seqs[k].chain || k == seqs.size() - 2)
        if (!(k > 0 && seqs[k].chain && k != seqs.size() - 2))
          idle_then_launch(seqs[k], $urandom_range(1, 3));
      run_one(k, seqs[k], ch, nx, (k == seqs.size() - 2) ? 4 : 0);
    end
    @(negedge clk);
    check_idle("final", last_timeout);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/garnet_reset_seq.md
# garnet_reset_seq

Parametrised reset-pulse sequencer driving the reset inputs of `Garnet` and its sub-domains: GLB, CGRA array, processor interface and AXI4-Lite slave. It generates a clean low→high→low reset pulse on each of `NUM_CH` channels. Pre-reset length, assert length and per-channel staggered release are set at run time. With the watchdog option compiled in, it then waits for the DUT `interrupt` with a timeout. It replaces hard-coded initial-block reset generation and is synthesizable, so it can also sit in the FPGA/emulation top.

## Interface
Parameters:
- `NUM_CH`, 4, number of independent reset output channels (1..16)
- `CNT_WIDTH`, 8, width of pre/assert/stagger cycle counts
- `TO_WIDTH`, 16, width of interrupt-watchdog timeout count

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  synchronous, active-low block reset
- `start`  in  1  one-cycle request to run a sequence
- `pre_cycles`  in  CNT_WIDTH  cycles rst_out held low before assertion
- `assert_cycles`  in  CNT_WIDTH  cycles all channels held high
- `stagger`  in  CNT_WIDTH  cycles between release of channel i and channel i+1
- `rst_out`  out  NUM_CH  active-high resets to DUT domains, registered
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse at sequence completion
- `interrupt`  in  1  DUT interrupt (used only with watchdog)
- `to_cycles`  in  TO_WIDTH  watchdog limit (used only with watchdog)
- `timeout`  out  1  sticky: watchdog expired; cleared by next accepted `start` or reset

## Operation
- States: IDLE, PRE, ASSERT, RELEASE, WAIT_IRQ (watchdog build only), DONE.
- The block applies reset when `reset_n`=0 at a `clk` edge:
  - state→IDLE;
  - `rst_out`=0, `busy`=0, `done`=0, `timeout`=0;
  - all counters cleared.
  - Reset mid-sequence aborts immediately with the same values.
- IDLE/DONE: `start`=1 latches `pre_cycles`, `assert_cycles`, `stagger` and `to_cycles`, and clears `timeout`.
  - Next state is PRE, or ASSERT when `pre_cycles`=0.
  - `start` is ignored in all other states.
- PRE: `rst_out`=0 for exactly `pre_cycles` cycles, then ASSERT.
- ASSERT: `rst_out`=all ones for `assert_cycles` cycles, then RELEASE. `assert_cycles`=0 is treated as 1.
- RELEASE: channel i deasserts at RELEASE cycle i×`stagger`.
  - With `stagger`=0, all channels deassert together in the first RELEASE cycle.
  - After channel NUM_CH-1 deasserts, the next state is WAIT_IRQ (watchdog build) or DONE.
- Stagger arithmetic: internal release counter width is CNT_WIDTH+clog2(NUM_CH), so it never wraps.
- WAIT_IRQ: a counter increments each cycle.
  - `interrupt`=1 → DONE.
  - Counter reaching `to_cycles` without interrupt → `timeout`=1, DONE.
  - Interrupt and limit in the same cycle → interrupt wins, `timeout` stays 0.
  - `to_cycles`=0 → `timeout` set on first WAIT_IRQ cycle unless `interrupt`=1.
- DONE: `done`=1 for one cycle on entry, then the block idles in DONE (equivalent to IDLE).
- `busy`=1 in PRE, ASSERT, RELEASE and WAIT_IRQ, and 0 otherwise.

## Timing
- `start` sampled at edge k → state PRE (or ASSERT) visible after edge k; `busy`=1 from cycle k+1.
- First `rst_out`=1 cycle is cycle k+1+pre_cycles.
- All outputs are registered; no combinational path from any input to any output.
- Total `rst_out`[0] high time = max(assert_cycles,1) cycles.
- Channel i high time = max(assert_cycles,1) + i×stagger cycles.
- `done` asserts the cycle after the last channel release (no watchdog build), or the cycle after interrupt/timeout detection.
- Back-to-back: `start` in the same cycle `done`=1 is accepted and begins a new sequence next cycle.

## Configuration
- `GARNET_RESET_SEQ_WATCHDOG_EN` defined:
  - WAIT_IRQ state, watchdog counter and `timeout` logic are compiled in;
  - `interrupt` and `to_cycles` are used.
- Not defined:
  - RELEASE goes directly to DONE;
  - `interrupt` and `to_cycles` are ignored;
  - `timeout` is tied to 0.
- Port list is identical in both builds.

## Test plan
- Reset/defaults: hold `reset_n`=0 for 3 cycles → `rst_out`=0, `busy`=0, `done`=0, `timeout`=0; release reset, no `start` → outputs stay 0 for 20 cycles.
- Legacy pulse: NUM_CH=4, pre=3, assert=3, stagger=0 → `rst_out`=0 for 3 cycles, 4'hF for exactly 3 cycles, 0 afterwards; `done` pulses 1 cycle after release.
- Stagger: pre=0, assert=2, stagger=2 → ch0 high 2, ch1 high 4, ch2 high 6, ch3 high 8 cycles; `start` pulses during `busy` are ignored.
- Watchdog hit: build with macro, to_cycles=10, `interrupt` pulsed 5 cycles after release → `done`, `timeout`=0. Interrupt withheld → `timeout`=1 after exactly 10 WAIT_IRQ cycles, cleared by next `start`.
- Abort: `reset_n`=0 during ASSERT → next cycle `rst_out`=0, state IDLE. A new `start` runs a full correct sequence.
- Corner values: assert=0 → 1-cycle pulse. to_cycles=0 with `interrupt`=1 in the first WAIT_IRQ cycle → `timeout`=0. `start` coincident with `done` → new sequence starts next cycle.
